hilo_muldiv_unit: RTL and testbench

//  Parametrised multi-cycle HI/LO arithmetic unit for the execute stage: signed/unsigned

---
 rtl/hilo_muldiv_unit_if.sv | 34 +++
 rtl/hilo_muldiv_unit.sv | 207 ++++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_unit_if.sv
// hilo_muldiv_unit_if
//   Request/response bundle between the execute stage and the HI/LO unit.
//   master: execute stage (drives request and cancel, observes status and HI/LO)
//   slave : hilo_muldiv_unit
//   Signals:
//     in_valid/in_ready  request handshake, op/src1/src2 valid while in_valid
//     op                 0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6-7 no-op
//     cancel             flush of the in-flight operation
//     busy/done          operation in flight / one-cycle commit pulse
//     hi/lo              architectural HI/LO registers
interface hilo_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            cancel;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output in_valid, op, src1, src2, cancel,
        input  in_ready, busy, done, hi, lo
    );

    modport slave (
        input  in_valid, op, src1, src2, cancel,
        output in_ready, busy, done, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   Multi-cycle HI/LO unit: signed/unsigned multiply with MUL_STAGES cycles of
//   latency, radix-2 restoring divide (XLEN+1 cycles to done), MTHI/MTLO writes.
//   A cancel flushes the in-flight operation without touching HI/LO.
//   Ports:
//     clk    clock
//     reset  synchronous, active-high reset
//     bus    hilo_muldiv_unit_if.slave (handshake, operands, cancel, busy, done, hi, lo)
module hilo_muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 1
) (
    input  logic                clk,
    input  logic                reset,
    hilo_muldiv_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    localparam int CNT_W = $clog2(XLEN + MUL_STAGES + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STAGES - 1);
    // The last quotient bit is produced combinationally in FIX, so DIV runs XLEN-1 steps.
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 2);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // Full-width product; operands are extended to 2*XLEN so the truncated
    // product is exact for both signed and unsigned forms.
    function automatic logic [2*XLEN-1:0] mul_full(input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b,
                                                   input logic            sgn);
        logic signed [2*XLEN-1:0] ax;
        logic signed [2*XLEN-1:0] bx;
        ax = $signed({{XLEN{sgn & a[XLEN-1]}}, a});
        bx = $signed({{XLEN{sgn & b[XLEN-1]}}, b});
        return ax * bx;
    endfunction

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                  input logic            sgn);
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction

    // One restoring-division step: returns {remainder, quotient/dividend shift reg}.
    function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                   input logic [XLEN-1:0] quo,
                                                   input logic [XLEN-1:0] dvs);
        logic [XLEN:0] shifted;
        logic [XLEN:0] diff;
        shifted = {rem, quo[XLEN-1]};
        diff    = shifted - {1'b0, dvs};
        if (shifted >= {1'b0, dvs})
            return {diff[XLEN-1:0], quo[XLEN-2:0], 1'b1};
        return {shifted[XLEN-1:0], quo[XLEN-2:0], 1'b0};
    endfunction

    // Final {hi, lo}: divide-by-zero bypasses the sign fixup entirely.
    function automatic logic [2*XLEN-1:0] sign_fix(input logic [2*XLEN-1:0] fin,
                                                   input logic            neg_q,
                                                   input logic            neg_r,
                                                   input logic            dz,
                                                   input logic [XLEN-1:0] dvd);
        logic [XLEN-1:0] q;
        logic [XLEN-1:0] r;
        q = fin[XLEN-1:0];
        r = fin[2*XLEN-1:XLEN];
        if (dz)
            return {dvd, {XLEN{1'b1}}};
        return {neg_r ? -r : r, neg_q ? -q : q};
    endfunction

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic            done_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;

    logic [XLEN-1:0] mul_a_p0;
    logic [XLEN-1:0] mul_b_p0;
    logic            mul_sgn_p0;
    logic [XLEN-1:0] rem_p0;
    logic [XLEN-1:0] quo_p0;
    logic [XLEN-1:0] dvs_p0;
    logic [XLEN-1:0] dvd_p0;
    logic            neg_q_p0;
    logic            neg_r_p0;
    logic            dz_p0;

    logic            accept;
    logic            is_mul;
    logic            is_div;
    logic            div_sgn;
    logic [2*XLEN-1:0] mul_now;
    logic [2*XLEN-1:0] mul_res;
    logic [2*XLEN-1:0] fix_res;

    assign bus.in_ready = (state == IDLE) && !bus.cancel;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

    assign accept  = bus.in_valid && bus.in_ready;
    assign is_mul  = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    assign is_div  = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    assign div_sgn = (bus.op == OP_DIV);

    assign mul_now = mul_full(bus.src1, bus.src2, bus.op == OP_MULT);
    assign mul_res = mul_full(mul_a_p0, mul_b_p0, mul_sgn_p0);
    assign fix_res = sign_fix(div_step(rem_p0, quo_p0, dvs_p0), neg_q_p0, neg_r_p0,
                              dz_p0, dvd_p0);

    // Stage p0: operand capture at acceptance and divide iteration
    always_ff @(posedge clk) begin
        if (accept && is_mul) begin
            mul_a_p0   <= bus.src1;
            mul_b_p0   <= bus.src2;
            mul_sgn_p0 <= (bus.op == OP_MULT);
        end
        if (accept && is_div) begin
            rem_p0   <= '0;
            quo_p0   <= magnitude(bus.src1, div_sgn);
            dvs_p0   <= magnitude(bus.src2, div_sgn);
            neg_q_p0 <= div_sgn && (bus.src1[XLEN-1] ^ bus.src2[XLEN-1]);
            neg_r_p0 <= div_sgn && bus.src1[XLEN-1];
            dz_p0    <= (bus.src2 == '0);
            dvd_p0   <= bus.src1;
        end else if (state == DIV) begin
            {rem_p0, quo_p0} <= div_step(rem_p0, quo_p0, dvs_p0);
        end
    end

    // Control and commit: HI/LO only change together with a done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU: begin
                                if (MUL_STAGES == 1) begin
                                    {hi_q, lo_q} <= mul_now;
                                    done_q       <= 1'b1;
                                end else begin
                                    cnt   <= CNT_W'(1);
                                    state <= MUL;
                                end
                            end
                            OP_DIV, OP_DIVU: begin
                                cnt   <= '0;
                                state <= DIV;
                            end
                            OP_MTHI: begin
                                hi_q   <= bus.src1;
                                done_q <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo_q   <= bus.src1;
                                done_q <= 1'b1;
                            end
                            default: done_q <= 1'b1;
                        endcase
                    end
                end
                MUL: begin
                    if (bus.cancel) begin
                        state <= IDLE;
                    end else if (cnt == MUL_LAST) begin
                        {hi_q, lo_q} <= mul_res;
                        done_q       <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DIV: begin
                    if (bus.cancel) begin
                        state <= IDLE;
                    end else begin
                        if (cnt == DIV_LAST)
                            state <= FIX;
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (!bus.cancel) begin
                        {hi_q, lo_q} <= fix_res;
                        done_q       <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;
    localparam int XLEN   = 32;
    localparam int MUL_ST = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hilo_muldiv_unit_if #(.XLEN(XLEN)) bus ();

    hilo_muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(MUL_ST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Reference model: HI/LO after an operation, from plain integer arithmetic.
    function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] h,
                                           input logic [31:0] l);
        longint sa, sb2, q, r;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        case (o)
            3'd0: return 64'(sa * sb2);
            3'd1: return {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb2;
                r = sa % sb2;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            3'd4: return {a, l};
            3'd5: return {h, a};
            default: return {h, l};
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] o);
        if (o <= 3'd1) return MUL_ST;
        if (o <= 3'd3) return XLEN + 1;
        return 1;
    endfunction

    // Monitor: every done pulse is checked against the oldest expected result.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got hi=%h lo=%h, required no done", bus.hi, bus.lo);
            end else begin
                check("done_hilo", {bus.hi, bus.lo}, sb.pop_front());
            end
        end
    end

    // Present a request and hold it until accepted; returns after the acceptance
    // edge (+1) with the operands scrambled to expose late operand sampling.
    task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit align, output int waited);
        if (align) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.src1     = a;
        bus.src2     = b;
        waited       = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 after %0d cycles, required 1", waited);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.src1     = $urandom;
        bus.src2     = $urandom;
        bus.op       = 3'($urandom_range(0, 7));
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit align, output int waited);
        logic [63:0] e;
        send(o, a, b, align, waited);
        e = ref_op(o, a, b, mhi, mlo);
        sb.push_back(e);
        {mhi, mlo} = e;
    endtask

    task automatic wait_done(input int lat, input string name);
        int k = 1;
        int nbusy = 0;
        @(negedge clk);
        while (!bus.done && k < 100) begin
            if (bus.busy) nbusy++;
            @(posedge clk);
            #1;
            k++;
            @(negedge clk);
        end
        check({name, "_latency"}, 64'(k), 64'(lat));
        check({name, "_busy_cycles"}, 64'(nbusy), 64'(lat - 1));
        check({name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input string name);
        int w;
        issue(o, a, b, 1'b1, w);
        wait_done(lat_of(o), name);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 4))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'd0;
            3: return 32'($urandom_range(0, 300));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int w;
        logic [2:0] o;
        logic [31:0] a, b;
        int c;

        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.op       = '0;
        bus.src1     = '0;
        bus.src2     = '0;
        bus.cancel   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);

        // Multiply
        do_op(3'd0, 32'hFFFF_FFFE, 32'd3, "mult");
        check("mult_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        do_op(3'd1, 32'hFFFF_FFFE, 32'd3, "multu");
        check("multu_hilo", {bus.hi, bus.lo}, 64'h0000_0002_FFFF_FFFA);

        // Divide
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div");
        check("div_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(3'd3, 32'hFFFF_FFF9, 32'd2, "divu");
        check("divu_hilo", {bus.hi, bus.lo}, 64'h0000_0001_7FFF_FFFC);
        do_op(3'd3, 32'h0000_1234, 32'd0, "divu_by_zero");
        check("divu_by_zero_hilo", {bus.hi, bus.lo}, 64'h0000_1234_FFFF_FFFF);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        check("div_overflow_hilo", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

        // Cancel at iteration 10 of a divide
        send(3'd2, 32'd1000, 32'd7, 1'b1, w);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        bus.cancel = 1'b1;
        @(posedge clk);
        #1;
        bus.cancel = 1'b0;
        @(negedge clk);
        check("cancel_div_busy", 64'(bus.busy), 64'd0);
        check("cancel_div_in_ready", 64'(bus.in_ready), 64'd1);
        check("cancel_div_hilo", {bus.hi, bus.lo}, {mhi, mlo});
        repeat (30) @(posedge clk);

        // Cancel in the FIX cycle (cycle XLEN)
        send(3'd3, 32'd99, 32'd5, 1'b1, w);
        repeat (XLEN - 1) begin
            @(posedge clk);
            #1;
        end
        bus.cancel = 1'b1;
        @(negedge clk);
        check("cancel_fix_busy_before", 64'(bus.busy), 64'd1);
        @(posedge clk);
        #1;
        bus.cancel = 1'b0;
        repeat (3) @(negedge clk);
        check("cancel_fix_busy", 64'(bus.busy), 64'd0);
        check("cancel_fix_hilo", {bus.hi, bus.lo}, {mhi, mlo});

        // Cancel together with a request in IDLE
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.op       = 3'd4;
        bus.src1     = 32'h5555_5555;
        bus.cancel   = 1'b1;
        @(negedge clk);
        check("cancel_idle_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.cancel   = 1'b0;
        @(negedge clk);
        check("cancel_idle_hi", 64'(bus.hi), 64'(mhi));

        // Back-to-back MTHI / MTLO
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.op       = 3'd4;
        bus.src1     = 32'hDEAD_BEEF;
        sb.push_back({32'hDEAD_BEEF, mlo});
        mhi = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.op   = 3'd5;
        bus.src1 = 32'h0BAD_F00D;
        sb.push_back({mhi, 32'h0BAD_F00D});
        mlo = 32'h0BAD_F00D;
        @(negedge clk);
        check("mthi_done", 64'(bus.done), 64'd1);
        check("mthi_hi", 64'(bus.hi), 64'hDEAD_BEEF);
        check("mthi_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("mtlo_done", 64'(bus.done), 64'd1);
        check("mtlo_hilo", {bus.hi, bus.lo}, 64'hDEAD_BEEF_0BAD_F00D);

        // Request held while a divide runs
        issue(3'd2, 32'd12345, 32'hFFFF_FFF0, 1'b1, w);
        issue(3'd5, 32'h1357_9BDF, 32'd0, 1'b0, w);
        check("held_request_wait", 64'(w), 64'(XLEN));
        wait_done(1, "held_mtlo");

        // Randomized operations, some flushed mid-flight
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            if (o <= 3'd3 && $urandom_range(0, 5) == 0) begin
                send(o, a, b, 1'b1, w);
                c = $urandom_range(1, lat_of(o) - 1);
                repeat (c - 1) begin
                    @(posedge clk);
                    #1;
                end
                bus.cancel = 1'b1;
                @(posedge clk);
                #1;
                bus.cancel = 1'b0;
                @(negedge clk);
                check("rand_cancel_busy", 64'(bus.busy), 64'd0);
                check("rand_cancel_hilo", {bus.hi, bus.lo}, {mhi, mlo});
            end else begin
                do_op(o, a, b, "rand");
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (5) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_results: got %0d outstanding, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
